// File: rtl/sincos_nco_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sincos_nco_pipe : 3-stage sin/cos generator, direct-angle or NCO phase mode
// Revision 1.0
// ---------------------------------------------------------------------------
module sincos_nco_pipe #(
  parameter int ANGLE_W   = 12,
  parameter int ANGLE_MAX = 3600,
  parameter int OUT_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_i,
  input  logic               phase_clr_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [ANGLE_W-1:0] in_angle_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OUT_W-1:0]   out_sin_o,
  output logic [OUT_W-1:0]   out_cos_o,
  output logic [ANGLE_W-1:0] out_angle_o
);

  localparam int Q     = ANGLE_MAX / 4;
  localparam int MAG_W = OUT_W - 1;
  localparam int MAG   = 2**MAG_W - 1;
  localparam int AW    = $clog2(Q + 1);

  localparam logic [ANGLE_W:0]   c_max = (ANGLE_W+1)'(ANGLE_MAX);
  localparam logic [ANGLE_W-1:0] c_q1  = ANGLE_W'(Q);
  localparam logic [ANGLE_W-1:0] c_q2  = ANGLE_W'(2 * Q);
  localparam logic [ANGLE_W-1:0] c_q3  = ANGLE_W'(3 * Q);
  localparam logic [ANGLE_W-1:0] c_q4  = ANGLE_W'(4 * Q);

  // pi * 2^60; the tiny extra bias keeps exact .5 cases (sin 30deg) rounding up
  localparam logic signed [127:0] c_pi60 = 128'sh3243F6A8885A308D;
  localparam logic signed [127:0] c_half = (128'sd1 <<< 59) + (128'sd1 <<< 20);

  function automatic logic [MAG_W-1:0] sin_mag(input int k);
    logic signed [127:0] x, term, sum;
    x    = (c_pi60 * 128'(k)) / 128'(2 * Q);
    term = x;
    sum  = x;
    for (int n = 1; n <= 13; n++) begin
      term = (term * x) >>> 60;
      term = (term * x) >>> 60;
      term = -term / 128'(2 * n * (2 * n + 1));
      sum  = sum + term;
    end
    sum = (sum * 128'(MAG) + c_half) >>> 60;
    return sum[MAG_W-1:0];
  endfunction

  function automatic logic [ANGLE_W-1:0] wrap(input logic [ANGLE_W:0] x);
    return (x >= c_max) ? ANGLE_W'(x - c_max) : ANGLE_W'(x);
  endfunction

  logic [MAG_W-1:0] rom [0:Q];

  for (genvar k = 0; k <= Q; k++) begin : g_rom
    localparam logic [MAG_W-1:0] c_val = sin_mag(k);
    assign rom[k] = c_val;
  end

  logic               en, accept;
  logic [ANGLE_W-1:0] in_wrapped, a_d, acc_d, acc_q;
  logic [AW-1:0]      sin_addr_d, cos_addr_d;
  logic               sin_neg_d, cos_neg_d;

  logic               s1_valid_q, s1_sin_neg_q, s1_cos_neg_q;
  logic [AW-1:0]      s1_sin_addr_q, s1_cos_addr_q;
  logic [ANGLE_W-1:0] s1_angle_q;
  logic               s2_valid_q, s2_sin_neg_q, s2_cos_neg_q;
  logic [MAG_W-1:0]   s2_sin_mag_q, s2_cos_mag_q;
  logic [ANGLE_W-1:0] s2_angle_q;
  logic               out_valid_q;
  logic [OUT_W-1:0]   out_sin_q, out_cos_q;
  logic [ANGLE_W-1:0] out_angle_q;

  assign en         = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && en;
  assign in_wrapped = wrap({1'b0, in_angle_i});

  always_comb begin
    a_d   = in_wrapped;
    acc_d = acc_q;
    if (mode_i) begin
      a_d = phase_clr_i ? '0 : acc_q;
    end
    if (accept && mode_i) begin
      acc_d = phase_clr_i ? in_wrapped : wrap({1'b0, acc_q} + {1'b0, in_wrapped});
    end else if (phase_clr_i) begin
      acc_d = '0;
    end
  end

  // Quadrant fold: a == Q lands in quadrant 1 so both addresses stay in 0..Q
  always_comb begin
    sin_addr_d = AW'(a_d);
    cos_addr_d = AW'(c_q1 - a_d);
    sin_neg_d  = 1'b0;
    cos_neg_d  = 1'b0;
    if (a_d >= c_q3) begin
      sin_addr_d = AW'(c_q4 - a_d);
      cos_addr_d = AW'(a_d - c_q3);
      sin_neg_d  = 1'b1;
    end else if (a_d >= c_q2) begin
      sin_addr_d = AW'(a_d - c_q2);
      cos_addr_d = AW'(c_q3 - a_d);
      sin_neg_d  = 1'b1;
      cos_neg_d  = 1'b1;
    end else if (a_d >= c_q1) begin
      sin_addr_d = AW'(c_q2 - a_d);
      cos_addr_d = AW'(a_d - c_q1);
      cos_neg_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_sin_neg_q  <= 1'b0;
      s1_cos_neg_q  <= 1'b0;
      s1_sin_addr_q <= '0;
      s1_cos_addr_q <= '0;
      s1_angle_q    <= '0;
      s2_valid_q    <= 1'b0;
      s2_sin_neg_q  <= 1'b0;
      s2_cos_neg_q  <= 1'b0;
      s2_sin_mag_q  <= '0;
      s2_cos_mag_q  <= '0;
      s2_angle_q    <= '0;
      out_valid_q   <= 1'b0;
      out_sin_q     <= '0;
      out_cos_q     <= '0;
      out_angle_q   <= '0;
    end else begin
      acc_q <= acc_d;
      if (en) begin
        s1_valid_q    <= in_valid_i;
        s1_sin_neg_q  <= sin_neg_d;
        s1_cos_neg_q  <= cos_neg_d;
        s1_sin_addr_q <= sin_addr_d;
        s1_cos_addr_q <= cos_addr_d;
        s1_angle_q    <= a_d;
        s2_valid_q    <= s1_valid_q;
        s2_sin_neg_q  <= s1_sin_neg_q;
        s2_cos_neg_q  <= s1_cos_neg_q;
        s2_sin_mag_q  <= rom[s1_sin_addr_q];
        s2_cos_mag_q  <= rom[s1_cos_addr_q];
        s2_angle_q    <= s1_angle_q;
        out_valid_q   <= s2_valid_q;
        if (s2_valid_q) begin
          out_sin_q   <= s2_sin_neg_q ? -{1'b0, s2_sin_mag_q} : {1'b0, s2_sin_mag_q};
          out_cos_q   <= s2_cos_neg_q ? -{1'b0, s2_cos_mag_q} : {1'b0, s2_cos_mag_q};
          out_angle_q <= s2_angle_q;
        end
      end
    end
  end

  assign in_ready_o  = en;
  assign out_valid_o = out_valid_q;
  assign out_sin_o   = out_sin_q;
  assign out_cos_o   = out_cos_q;
  assign out_angle_o = out_angle_q;

endmodule
`default_nettype wire

// File: tb/tb_sincos_nco_pipe.sv
`default_nettype none
// Testbench for sincos_nco_pipe: scoreboard of expected (sin, cos, angle) per accepted beat.
module tb_sincos_nco_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic        phase_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_angle = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [9:0]  out_sin, out_cos;
  logic [11:0] out_angle;

  sincos_nco_pipe #(.ANGLE_W(12), .ANGLE_MAX(3600), .OUT_W(10)) dut (
    .clk(clk), .rst(rst), .mode_i(mode), .phase_clr_i(phase_clr),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_angle_i(in_angle),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sin_o(out_sin), .out_cos_o(out_cos), .out_angle_o(out_angle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  s;
    logic [9:0]  c;
    logic [11:0] a;
  } exp_t;

  exp_t  exp_q[$];
  int    acc_cyc_q[$];
  int    out_cyc_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    acc_m = 0;
  string tname = "init";

  localparam real PI = 3.14159265358979323846;

  always @(posedge clk) cyc++;

  function automatic int rnd(input real r);
    if (r >= 0.0) return int'($floor(r + 0.5 + 1.0e-9));
    return -int'($floor(-r + 0.5 + 1.0e-9));
  endfunction

  function automatic int wrapm(input int x);
    return (x >= 3600) ? x - 3600 : x;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      out_cyc_q.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s unexpected output sin=%0d cos=%0d angle=%0d, required none",
                 tname, $signed(out_sin), $signed(out_cos), out_angle);
      end else begin
        e = exp_q.pop_front();
        if ({out_sin, out_cos, out_angle} !== e) begin
          bad++;
          $display("FAIL %s result sin=%0d cos=%0d angle=%0d, required sin=%0d cos=%0d angle=%0d",
                   tname, $signed(out_sin), $signed(out_cos), out_angle,
                   $signed(e.s), $signed(e.c), e.a);
        end
      end
      total++;
      if (out_sin === 10'h200 || out_cos === 10'h200) begin
        bad++;
        $display("FAIL %s range sin=%0d cos=%0d, required magnitude <= 511",
                 tname, $signed(out_sin), $signed(out_cos));
      end
    end
  end

  // Drive one beat, hold until accepted, then push its expected result.
  task automatic send(input logic m, input logic clr, input int ang,
                      input bit use_c, input int es, input int ec, input int ea);
    int a;
    exp_t e;
    mode = m; phase_clr = clr; in_angle = 12'(ang); in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (m) begin
          a = clr ? 0 : acc_m;
          acc_m = clr ? wrapm(ang) : wrapm(acc_m + wrapm(ang));
        end else begin
          a = wrapm(ang);
          if (clr) acc_m = 0;
        end
        if (use_c) begin
          e.s = 10'(es); e.c = 10'(ec); e.a = 12'(ea);
        end else begin
          e.s = 10'(rnd(511.0 * $sin(2.0 * PI * a / 3600.0)));
          e.c = 10'(rnd(511.0 * $cos(2.0 * PI * a / 3600.0)));
          e.a = 12'(a);
        end
        exp_q.push_back(e);
        acc_cyc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        in_valid = 1'b0; phase_clr = 1'b0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL %s in_ready timeout, required acceptance within 200 cycles", tname);
    in_valid = 1'b0; phase_clr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100 && (exp_q.size() != 0 || out_valid); t++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s drain pending=%0d, required 0", tname, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    tname = "reset";
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_sin, out_cos, out_angle, in_ready} !== {1'b0, 10'd0, 10'd0, 12'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_async valid=%b sin=%0d cos=%0d angle=%0d ready=%b, required 0 0 0 0 1",
               out_valid, out_sin, out_cos, out_angle, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, out_sin, out_cos, out_angle} !== {1'b0, 10'd0, 10'd0, 12'd0}) begin
      bad++;
      $display("FAIL reset_release valid=%b sin=%0d cos=%0d angle=%0d, required all 0",
               out_valid, out_sin, out_cos, out_angle);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_quadrants();
    int lat;
    tname = "quadrants";
    acc_cyc_q.delete(); out_cyc_q.delete();
    send(0, 0, 0,    1, 0,    511,  0);
    send(0, 0, 900,  1, 511,  0,    900);
    send(0, 0, 1800, 1, 0,    -511, 1800);
    send(0, 0, 2700, 1, -511, 0,    2700);
    wait_drain();
    total++;
    if (out_cyc_q.size() != 4) begin
      bad++;
      $display("FAIL quadrants_count got=%0d, required 4", out_cyc_q.size());
    end else begin
      lat = out_cyc_q[0] - acc_cyc_q[0];
      total++;
      if (lat != 2) begin
        bad++;
        $display("FAIL quadrants_latency edges=%0d, required 2 after the accept edge", lat);
      end
      total++;
      if (out_cyc_q[3] - out_cyc_q[0] != 3) begin
        bad++;
        $display("FAIL quadrants_b2b span=%0d, required 3", out_cyc_q[3] - out_cyc_q[0]);
      end
    end
  endtask

  task automatic test_fold_wrap();
    tname = "fold_wrap";
    send(0, 0, 300,  1, 256, 443, 300);
    send(0, 0, 3700, 1, 89,  503, 100);
    send(0, 0, 100,  1, 89,  503, 100);
    send(0, 0, 1200, 0, 0, 0, 0);
    send(0, 0, 3599, 0, 0, 0, 0);
    wait_drain();
  endtask

  task automatic test_nco();
    tname = "nco";
    send(1, 1, 900, 1, 0,    511,  0);
    send(1, 0, 900, 1, 511,  0,    900);
    send(1, 0, 900, 1, 0,    -511, 1800);
    send(1, 0, 900, 1, -511, 0,    2700);
    send(1, 0, 900, 1, 0,    511,  0);
    send(1, 0, 4000, 0, 0, 0, 0);
    send(1, 0, 1333, 0, 0, 0, 0);
    send(1, 0, 0,    0, 0, 0, 0);
    wait_drain();
  endtask

  task automatic test_stall();
    logic [31:0] held;
    tname = "stall";
    out_cyc_q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, 0, i * 450 + 37, 0, 0, 0, 0);
      end
      begin
        for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        held = {out_sin, out_cos, out_angle};
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          total++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_sin, out_cos, out_angle} !== held) begin
            bad++;
            $display("FAIL stall_hold ready=%b valid=%b data=%h, required 0 1 %h",
                     in_ready, out_valid, {out_sin, out_cos, out_angle}, held);
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    total++;
    if (out_cyc_q.size() != 8) begin
      bad++;
      $display("FAIL stall_count got=%0d, required 8", out_cyc_q.size());
    end
  endtask

  task automatic test_async_reset();
    tname = "async_reset";
    send(1, 1, 500, 0, 0, 0, 0);
    send(1, 0, 500, 0, 0, 0, 0);
    send(1, 0, 500, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_sin, out_cos, out_angle} !== {1'b0, 10'd0, 10'd0, 12'd0}) begin
      bad++;
      $display("FAIL async_reset_clear valid=%b sin=%0d cos=%0d angle=%0d, required all 0",
               out_valid, out_sin, out_cos, out_angle);
    end
    exp_q.delete();
    acc_m = 0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_flush valid=%b, required 0", out_valid);
    end
    @(posedge clk); #1;
    send(1, 0, 450, 1, 0, 511, 0);
    send(1, 0, 450, 1, 361, 361, 450);
    wait_drain();
  endtask

  task automatic test_sweep();
    tname = "sweep";
    for (int a = 0; a < 3600; a++) send(0, 0, a, 0, 0, 0, 0);
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout in %s", tname);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_quadrants();
    test_fold_wrap();
    test_nco();
    test_stall();
    test_async_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
